// File: rtl/bno085_report_parser.sv
// SHTP byte-stream parser: decodes SH-2 rotation vector and calibrated gyro input reports into held output words.
// Optional build macro PARSER_SEQ_CHECK_EN enables SHTP sequence-gap counting on the report channel.
module bno085_report_parser #(
  parameter logic [7:0] CHANNEL = 8'd3,
  parameter logic [7:0] QUAT_ID = 8'h05,
  parameter logic [7:0] GYRO_ID = 8'h02
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        pkt_start,
  output logic        quat1_valid,
  output logic [15:0] quat1_w,
  output logic [15:0] quat1_x,
  output logic [15:0] quat1_y,
  output logic [15:0] quat1_z,
  output logic        gyro1_valid,
  output logic [15:0] gyro1_x,
  output logic [15:0] gyro1_y,
  output logic [15:0] gyro1_z,
  output logic        quat_update,
  output logic        gyro_update,
  output logic [7:0]  trunc_count,
  output logic [7:0]  seq_err_count
);
  // Input contract: a byte is consumed on every cycle rx_valid is high; there is no backpressure.
  typedef enum logic [2:0] {S_IDLE, S_HDR, S_RPT_ID, S_RPT_BODY, S_SKIP} state_t;

  state_t            state_q, state_d;
  logic [1:0]        hdr_idx_q, hdr_idx_d;
  logic [14:0]       len_q, len_d;
  logic [7:0]        chan_q, chan_d;
  logic [14:0]       remain_q, remain_d;
  logic [7:0]        rpt_id_q, rpt_id_d;
  logic [3:0]        rpt_size_q, rpt_size_d;
  logic [3:0]        rpt_idx_q, rpt_idx_d;
  logic [3:0][15:0]  stg_q, stg_d;
  logic              quat_valid_q, quat_valid_d, gyro_valid_q, gyro_valid_d;
  logic [15:0]       quat_w_q, quat_w_d, quat_x_q, quat_x_d, quat_y_q, quat_y_d, quat_z_q, quat_z_d;
  logic [15:0]       gyro_x_q, gyro_x_d, gyro_y_q, gyro_y_d, gyro_z_q, gyro_z_d;
  logic              quat_upd_q, quat_upd_d, gyro_upd_q, gyro_upd_d;
  logic [7:0]        trunc_q, trunc_d;
  logic              trunc_inc;
  logic              last_payload;
  logic [1:0]        wsel;

  assign last_payload = (remain_q == 15'd1);
  // Report bytes 4..11 map to staging words 0..3 (two bytes each, little-endian).
  assign wsel = rpt_idx_q[2:1] - 2'd2;

  always_comb begin
    state_d      = state_q;
    hdr_idx_d    = hdr_idx_q;
    len_d        = len_q;
    chan_d       = chan_q;
    remain_d     = remain_q;
    rpt_id_d     = rpt_id_q;
    rpt_size_d   = rpt_size_q;
    rpt_idx_d    = rpt_idx_q;
    stg_d        = stg_q;
    quat_valid_d = quat_valid_q;
    gyro_valid_d = gyro_valid_q;
    quat_w_d     = quat_w_q;
    quat_x_d     = quat_x_q;
    quat_y_d     = quat_y_q;
    quat_z_d     = quat_z_q;
    gyro_x_d     = gyro_x_q;
    gyro_y_d     = gyro_y_q;
    gyro_z_d     = gyro_z_q;
    quat_upd_d   = 1'b0;
    gyro_upd_d   = 1'b0;
    trunc_inc    = 1'b0;
    if (rx_valid) begin
      if (pkt_start) begin
        trunc_inc = (state_q == S_RPT_BODY);
        state_d   = S_HDR;
        hdr_idx_d = 2'd1;
        len_d     = {7'd0, rx_byte};
      end else begin
        case (state_q)
          S_HDR: begin
            case (hdr_idx_q)
              2'd1: begin
                len_d     = {rx_byte[6:0], len_q[7:0]};
                hdr_idx_d = 2'd2;
                if ({rx_byte[6:0], len_q[7:0]} < 15'd5) state_d = S_IDLE;
              end
              2'd2: begin
                chan_d    = rx_byte;
                hdr_idx_d = 2'd3;
              end
              2'd3: begin
                remain_d  = len_q - 15'd4;
                hdr_idx_d = 2'd0;
                state_d   = (chan_q == CHANNEL) ? S_RPT_ID : S_SKIP;
              end
              default: state_d = S_IDLE;
            endcase
          end
          S_RPT_ID: begin
            remain_d  = remain_q - 15'd1;
            rpt_id_d  = rx_byte;
            rpt_idx_d = 4'd1;
            if (rx_byte == 8'hFB || rx_byte == 8'hFA) rpt_size_d = 4'd5;
            else if (rx_byte == GYRO_ID)              rpt_size_d = 4'd10;
            else if (rx_byte == QUAT_ID)              rpt_size_d = 4'd14;
            else if (rx_byte == 8'h08)                rpt_size_d = 4'd12;
            else                                      rpt_size_d = 4'd0;
            if (rpt_size_d == 4'd0) begin
              state_d = last_payload ? S_IDLE : S_SKIP;
            end else if (last_payload) begin
              trunc_inc = 1'b1;
              state_d   = S_IDLE;
            end else begin
              state_d = S_RPT_BODY;
            end
          end
          S_RPT_BODY: begin
            remain_d  = remain_q - 15'd1;
            rpt_idx_d = rpt_idx_q + 4'd1;
            if (rpt_idx_q >= 4'd4 && rpt_idx_q <= 4'd11) begin
              if (rpt_idx_q[0]) stg_d[wsel][15:8] = rx_byte;
              else              stg_d[wsel][7:0]  = rx_byte;
            end
            if (rpt_idx_q == rpt_size_q - 4'd1) begin
              if (rpt_id_q == QUAT_ID) begin
                quat_x_d     = stg_d[0];
                quat_y_d     = stg_d[1];
                quat_z_d     = stg_d[2];
                quat_w_d     = stg_d[3];
                quat_valid_d = 1'b1;
                quat_upd_d   = 1'b1;
              end else if (rpt_id_q == GYRO_ID) begin
                gyro_x_d     = stg_d[0];
                gyro_y_d     = stg_d[1];
                gyro_z_d     = stg_d[2];
                gyro_valid_d = 1'b1;
                gyro_upd_d   = 1'b1;
              end
              state_d = last_payload ? S_IDLE : S_RPT_ID;
            end else if (last_payload) begin
              trunc_inc = 1'b1;
              state_d   = S_IDLE;
            end
          end
          S_SKIP: begin
            remain_d = remain_q - 15'd1;
            if (last_payload) state_d = S_IDLE;
          end
          default: ;
        endcase
      end
    end
    trunc_d = (trunc_inc && trunc_q != 8'hFF) ? trunc_q + 8'd1 : trunc_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;      hdr_idx_q <= '0;  len_q <= '0;       chan_q <= '0;
      remain_q <= '0;         rpt_id_q <= '0;   rpt_size_q <= '0;  rpt_idx_q <= '0;
      stg_q <= '0;            quat_valid_q <= 1'b0;  gyro_valid_q <= 1'b0;
      quat_w_q <= '0;         quat_x_q <= '0;   quat_y_q <= '0;    quat_z_q <= '0;
      gyro_x_q <= '0;         gyro_y_q <= '0;   gyro_z_q <= '0;
      quat_upd_q <= 1'b0;     gyro_upd_q <= 1'b0;    trunc_q <= '0;
    end else begin
      state_q <= state_d;     hdr_idx_q <= hdr_idx_d;  len_q <= len_d;  chan_q <= chan_d;
      remain_q <= remain_d;   rpt_id_q <= rpt_id_d;    rpt_size_q <= rpt_size_d;  rpt_idx_q <= rpt_idx_d;
      stg_q <= stg_d;         quat_valid_q <= quat_valid_d;  gyro_valid_q <= gyro_valid_d;
      quat_w_q <= quat_w_d;   quat_x_q <= quat_x_d;    quat_y_q <= quat_y_d;  quat_z_q <= quat_z_d;
      gyro_x_q <= gyro_x_d;   gyro_y_q <= gyro_y_d;    gyro_z_q <= gyro_z_d;
      quat_upd_q <= quat_upd_d;  gyro_upd_q <= gyro_upd_d;  trunc_q <= trunc_d;
    end
  end

`ifdef PARSER_SEQ_CHECK_EN
  logic [7:0] seq_last_q, seq_last_d, seq_cnt_q, seq_cnt_d;
  logic       seq_seen_q, seq_seen_d, seq_strobe;

  // Sequence byte of a header on the report channel; rejected short packets never reach byte 3.
  assign seq_strobe = rx_valid && !pkt_start && state_q == S_HDR && hdr_idx_q == 2'd3 && chan_q == CHANNEL;

  always_comb begin
    seq_last_d = seq_last_q;
    seq_seen_d = seq_seen_q;
    seq_cnt_d  = seq_cnt_q;
    if (seq_strobe) begin
      if (seq_seen_q && rx_byte != seq_last_q + 8'd1 && seq_cnt_q != 8'hFF) seq_cnt_d = seq_cnt_q + 8'd1;
      seq_last_d = rx_byte;
      seq_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_last_q <= '0;
      seq_seen_q <= 1'b0;
      seq_cnt_q  <= '0;
    end else begin
      seq_last_q <= seq_last_d;
      seq_seen_q <= seq_seen_d;
      seq_cnt_q  <= seq_cnt_d;
    end
  end

  assign seq_err_count = seq_cnt_q;
`else
  assign seq_err_count = 8'd0;
`endif

  assign quat1_valid = quat_valid_q;
  assign quat1_w     = quat_w_q;
  assign quat1_x     = quat_x_q;
  assign quat1_y     = quat_y_q;
  assign quat1_z     = quat_z_q;
  assign gyro1_valid = gyro_valid_q;
  assign gyro1_x     = gyro_x_q;
  assign gyro1_y     = gyro_y_q;
  assign gyro1_z     = gyro_z_q;
  assign quat_update = quat_upd_q;
  assign gyro_update = gyro_upd_q;
  assign trunc_count = trunc_q;
endmodule

// File: tb/tb_bno085_report_parser.sv
// Directed bench for bno085_report_parser: packet driver tasks, update scoreboard, and final report.
`timescale 1ns/1ps
module tb_bno085_report_parser;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        pkt_start = 1'b0;
  logic        quat1_valid, gyro1_valid, quat_update, gyro_update;
  logic [15:0] quat1_w, quat1_x, quat1_y, quat1_z, gyro1_x, gyro1_y, gyro1_z;
  logic [7:0]  trunc_count, seq_err_count;

  int tests = 0;
  int fails = 0;
  logic [63:0] quat_exp_q[$];   // {w, x, y, z}
  logic [47:0] gyro_exp_q[$];   // {x, y, z}
  logic [7:0]  pay[$];
  logic [7:0]  exp_seq_err;

  bno085_report_parser dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte), .pkt_start(pkt_start),
    .quat1_valid(quat1_valid), .quat1_w(quat1_w), .quat1_x(quat1_x), .quat1_y(quat1_y), .quat1_z(quat1_z),
    .gyro1_valid(gyro1_valid), .gyro1_x(gyro1_x), .gyro1_y(gyro1_y), .gyro1_z(gyro1_z),
    .quat_update(quat_update), .gyro_update(gyro_update),
    .trunc_count(trunc_count), .seq_err_count(seq_err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every update pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && quat_update) begin
      if (quat_exp_q.size() == 0) check("quat_unexpected_pulse", 64'd1, 64'd0);
      else begin
        check("quat_sb_words", {quat1_w, quat1_x, quat1_y, quat1_z}, quat_exp_q.pop_front());
        check("quat_sb_valid", {63'd0, quat1_valid}, 64'd1);
      end
    end
    if (!rst && gyro_update) begin
      if (gyro_exp_q.size() == 0) check("gyro_unexpected_pulse", 64'd1, 64'd0);
      else begin
        check("gyro_sb_words", {16'd0, gyro1_x, gyro1_y, gyro1_z}, {16'd0, gyro_exp_q.pop_front()});
        check("gyro_sb_valid", {63'd0, gyro1_valid}, 64'd1);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic s);
    @(negedge clk);
    rx_valid  = 1'b1;
    rx_byte   = b;
    pkt_start = s;
    @(posedge clk);
    #1;
    rx_valid  = 1'b0;
    pkt_start = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] chan, input logic [7:0] seq, input int len,
                             input int nsend, input bit gaps);
    logic [14:0] l;
    l = len[14:0];
    send_byte(l[7:0], 1'b1);
    send_byte({1'b0, l[14:8]}, 1'b0);
    send_byte(chan, 1'b0);
    send_byte(seq, 1'b0);
    for (int i = 0; i < nsend; i++) begin
      if (gaps && i > 0) @(negedge clk);
      send_byte(pay[i], 1'b0);
    end
    pay.delete();
  endtask

  task automatic send_full(input logic [7:0] chan, input logic [7:0] seq, input bit gaps);
    send_packet(chan, seq, pay.size() + 4, pay.size(), gaps);
  endtask

  task automatic add_w(input logic [15:0] w);
    pay.push_back(w[7:0]);
    pay.push_back(w[15:8]);
  endtask

  task automatic add_ts();
    pay.push_back(8'hFB);
    for (int i = 0; i < 4; i++) pay.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic add_quat(input logic [15:0] i, input logic [15:0] j, input logic [15:0] k, input logic [15:0] r);
    pay.push_back(8'h05);
    for (int n = 0; n < 3; n++) pay.push_back(8'($urandom_range(0, 255)));
    add_w(i); add_w(j); add_w(k); add_w(r);
    add_w(16'($urandom_range(0, 65535)));
  endtask

  task automatic add_gyro(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    pay.push_back(8'h02);
    for (int n = 0; n < 3; n++) pay.push_back(8'($urandom_range(0, 255)));
    add_w(x); add_w(y); add_w(z);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx_valid = 1'b0;
    pkt_start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_quat"}, {quat1_w, quat1_x, quat1_y, quat1_z}, 64'd0);
    check({tag, "_gyro"}, {16'd0, gyro1_x, gyro1_y, gyro1_z}, 64'd0);
    check({tag, "_flags"}, {60'd0, quat1_valid, gyro1_valid, quat_update, gyro_update}, 64'd0);
    check({tag, "_counts"}, {48'd0, trunc_count, seq_err_count}, 64'd0);
  endtask

  localparam logic [63:0] Q1 = {16'h4000, 16'h1234, 16'hFEDC, 16'h0001};
  localparam logic [47:0] G1 = {16'hFFFF, 16'h0200, 16'h8000};

  initial begin
    // Reset state
    do_reset();
    check_all_zero("reset");

    // Timestamp + quaternion on channel 3 (length 0x0017)
    add_ts();
    add_quat(16'h1234, 16'hFEDC, 16'h0001, 16'h4000);
    check("pkt1_len", 64'(pay.size() + 4), 64'h17);
    quat_exp_q.push_back(Q1);
    send_full(8'd3, 8'd0, 1'b0);
    @(negedge clk);
    check("quat_pulse", {63'd0, quat_update}, 64'd1);
    check("quat_words", {quat1_w, quat1_x, quat1_y, quat1_z}, Q1);
    @(negedge clk);
    check("quat_pulse_width", {63'd0, quat_update}, 64'd0);
    check("gyro_untouched", {15'd0, gyro1_valid, gyro1_x, gyro1_y, gyro1_z}, 64'd0);

    // Gyro with rx_valid toggling every other cycle
    add_gyro(16'hFFFF, 16'h0200, 16'h8000);
    gyro_exp_q.push_back(G1);
    send_full(8'd3, 8'd1, 1'b1);
    @(negedge clk);
    check("gyro_latency_pulse", {63'd0, gyro_update}, 64'd1);
    check("gyro_words", {16'd0, gyro1_x, gyro1_y, gyro1_z}, {16'd0, G1});

    // Wrong channel is skipped
    add_quat(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD);
    send_full(8'd2, 8'd9, 1'b0);
    repeat (3) @(negedge clk);
    check("chan2_quat_hold", {quat1_w, quat1_x, quat1_y, quat1_z}, Q1);

    // Truncation by packet end (3 bytes early)
    add_quat(16'h1111, 16'h2222, 16'h3333, 16'h4444);
    send_packet(8'd3, 8'd2, 4 + 11, 11, 1'b0);
    @(negedge clk);
    check("trunc_end", {56'd0, trunc_count}, 64'd1);
    // Truncation by pkt_start at report byte 7, then a timestamp-only packet
    add_quat(16'h5555, 16'h6666, 16'h7777, 16'h0888);
    send_packet(8'd3, 8'd3, 4 + 14, 7, 1'b0);
    add_ts();
    send_full(8'd3, 8'd4, 1'b0);
    @(negedge clk);
    check("trunc_abort", {56'd0, trunc_count}, 64'd2);
    check("trunc_quat_hold", {quat1_w, quat1_x, quat1_y, quat1_z}, Q1);

    // Unknown report ID skips the rest of the packet
    pay.push_back(8'h7E);
    add_quat(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    send_full(8'd3, 8'd5, 1'b0);
    @(negedge clk);
    check("unknown_quat_hold", {quat1_w, quat1_x, quat1_y, quat1_z}, Q1);
    check("unknown_no_trunc", {56'd0, trunc_count}, 64'd2);

    // Short packet (length 4) followed by stray bytes without pkt_start
    send_byte(8'h04, 1'b1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h06, 1'b0);
    add_quat(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    for (int i = 0; i < 14; i++) send_byte(pay[i], 1'b0);
    pay.delete();
    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    @(negedge clk);
    check("idle_quat_hold", {quat1_w, quat1_x, quat1_y, quat1_z}, Q1);
    check("idle_gyro_hold", {16'd0, gyro1_x, gyro1_y, gyro1_z}, {16'd0, G1});
    check("seq_in_order", {56'd0, seq_err_count}, 64'd0);
    check("sb_drained_1", 64'(quat_exp_q.size() + gyro_exp_q.size()), 64'd0);

    // Reset mid-report drops everything
    add_quat(16'h1357, 16'h2468, 16'h3579, 16'h4680);
    send_packet(8'd3, 8'd6, 4 + 14, 8, 1'b0);
    do_reset();
    check_all_zero("mid_reset");

    // Sequence numbers 0,1,3,4 with a gyro report each
    for (int p = 0; p < 4; p++) begin
      logic [7:0]  s;
      logic [15:0] gx, gy, gz;
      s  = (p < 2) ? 8'(p) : 8'(p + 1);
      gx = 16'($urandom_range(0, 65535));
      gy = 16'($urandom_range(0, 65535));
      gz = 16'($urandom_range(0, 65535));
      add_gyro(gx, gy, gz);
      gyro_exp_q.push_back({gx, gy, gz});
      send_full(8'd3, s, 1'b0);
    end
    repeat (2) @(negedge clk);
`ifdef PARSER_SEQ_CHECK_EN
    exp_seq_err = 8'd1;
`else
    exp_seq_err = 8'd0;
`endif
    check("seq_err_count", {56'd0, seq_err_count}, {56'd0, exp_seq_err});
    check("seq_trunc_zero", {56'd0, trunc_count}, 64'd0);
    check("sb_drained_2", 64'(quat_exp_q.size() + gyro_exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bno085_report_parser.md
# bno085_report_parser

Byte-stream parser between the BNO085 SPI host interface and `spi_slave_mcu`. It consumes raw SHTP bytes clocked out of the sensor and decodes the SH-2 input reports on channel 3. It extracts Rotation Vector (0x05) and Calibrated Gyroscope (0x02) data. It presents them as the held, signed 16-bit `quat1_*` / `gyro1_*` words and valid levels that `spi_slave_mcu` snapshots.

## Interface
Parameters:
- `CHANNEL`, 3: SHTP channel carrying input sensor reports; all other channels are skipped.
- `QUAT_ID`, 8'h05: report ID decoded as quaternion.
- `GYRO_ID`, 8'h02: report ID decoded as gyroscope.

Ports:
- `clk`  in  1  FPGA system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `rx_valid`  in  1  `rx_byte` carries a byte this cycle.
- `rx_byte`  in  8  SHTP byte from the SPI host.
- `pkt_start`  in  1  qualified by `rx_valid`; marks that byte as header byte 0 of a new packet.
- `quat1_valid`  out  1  level; set after the first good quaternion report.
- `quat1_w`, `quat1_x`, `quat1_y`, `quat1_z`  out  16 each  signed Q14 quaternion (real, i, j, k).
- `gyro1_valid`  out  1  level; set after the first good gyro report.
- `gyro1_x`, `gyro1_y`, `gyro1_z`  out  16 each  signed Q9 rad/s.
- `quat_update`, `gyro_update`  out  1 each  one-cycle pulse on each new sample.
- `trunc_count`  out  8  saturating count of reports cut off by packet end or `pkt_start`.
- `seq_err_count`  out  8  saturating count of SHTP sequence gaps.

## Operation
- States:
  - IDLE: wait for `pkt_start`.
  - HDR: bytes 0–3.
  - RPT_ID: next report ID.
  - RPT_BODY: report bytes.
  - SKIP: discard to packet end.
- Header decode:
  - Length = {byte1[6:0], byte0}; the bit-15 continuation flag is masked.
  - payload = length − 4.
  - byte2 = channel, byte3 = sequence.
- Packet rejection: length < 5, or channel ≠ `CHANNEL`, goes to SKIP (length < 5 goes straight to IDLE).
- RPT_ID decodes the report ID to a total report size:
  - 0xFB (timestamp): 5 bytes.
  - 0xFA: 5 bytes.
  - `GYRO_ID`: 10 bytes.
  - `QUAT_ID`: 14 bytes.
  - 0x08: 12 bytes.
  - Unknown ID: go to SKIP.
- Field layout: bytes are little-endian.
  - Quaternion: i = bytes 4–5, j = 6–7, k = 8–9, real = 10–11; accuracy bytes 12–13 are ignored.
  - Gyro: x = 4–5, y = 6–7, z = 8–9.
- Fields assemble into staging registers. Outputs are copied atomically only when the final report byte is accepted, so there are no partial updates. Only `QUAT_ID` and `GYRO_ID` update outputs; the other known IDs are parsed for length and discarded.
- A 15-bit remaining-payload counter decrements on every accepted payload byte. When it reaches 0:
  - A report that is incomplete at that point increments `trunc_count` and its staging data is discarded.
  - The FSM returns to IDLE.
- Bytes received in IDLE without `pkt_start` are ignored.
- `pkt_start` in any state aborts the current packet and restarts in HDR with that byte as byte 0. An aborted mid-report counts as a truncation.
- `quat1_valid` and `gyro1_valid` stay high until `rst`.
- Both counters saturate at 255.

## Timing
- Reset values (cycle after `rst` sampled high):
  - FSM is in IDLE.
  - All data outputs are 0; both valids are 0.
  - Pulses are 0; both counters are 0.
- Latency: an output word, its valid, and its update pulse change on the cycle after the clock edge that accepts the report's last byte (one register stage).
- `quat_update` and `gyro_update` are high for exactly one cycle per report.
- `rx_valid` may be asserted on consecutive cycles; there is no backpressure.
- `rst` has priority over all inputs; it clears mid-packet state and drops any staged data.

## Configuration
- `PARSER_SEQ_CHECK_EN` defined:
  - Keeps the last channel-3 sequence number plus a seen flag.
  - When a header's byte3 ≠ (last + 1) mod 256 and the seen flag is set, `seq_err_count` increments; the packet is still parsed.
  - The seen flag is cleared by `rst`.
- `PARSER_SEQ_CHECK_EN` undefined: no sequence state is kept and `seq_err_count` is tied to 0.

## Test plan
- After reset, send one channel-3 packet: length 0x0017, header seq 0, timestamp report 0xFB + 4 bytes, then 0x05 report with i=0x1234, j=0xFEDC, k=0x0001, real=0x4000.
  - Required: `quat1_x`=0x1234, `quat1_y`=0xFEDC, `quat1_z`=0x0001, `quat1_w`=0x4000.
  - Required: one `quat_update` pulse and `quat1_valid`=1; gyro outputs stay 0.
- Send a 0x02 report with x=−1 (0xFFFF), y=0x0200, z=0x8000, delivered with `rx_valid` toggling every other cycle.
  - Required: `gyro1_x`=16'hFFFF, `gyro1_y`=16'h0200, `gyro1_z`=16'h8000, updating one cycle after the last byte.
- Send a packet on channel 2 containing valid-looking 0x05 bytes → all outputs unchanged.
- Send a 0x05 report whose packet length ends 3 bytes early, then a second case where `pkt_start` interrupts at report byte 7.
  - Required: outputs unchanged, no update pulse, `trunc_count` 0→1→2.
- Send a report ID 0x7E followed by a 0x05 report in the same packet → skipped; no update.
- With `PARSER_SEQ_CHECK_EN`, send sequence numbers 0, 1, 3, 4.
  - Required: `seq_err_count`=1, and all packets are still decoded.
